// File: rtl/load_store_unit.sv
// load_store_unit: turns core byte/half/word requests into aligned word accesses with extract and read-modify-write
module load_store_unit #(
  parameter int MEM_BYTES = 64,
  parameter int ADDR_W = 32
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [31:0]       rsp_rdata,
  output logic [31:0]       mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);
  localparam logic [2:0] IDLE = 3'd0, RD = 3'd1, WR = 3'd2, RESP = 3'd3, ERR = 3'd4;
  logic [2:0] state, state_n;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0] f3_q;
  logic store_q;
  logic [31:0] wdata_q, rbuf;
  logic accept, bad;
  logic [1:0] size_m1;
  logic [ADDR_W:0] last;
  logic [7:0] lane_b;
  logic [15:0] lane_h;
  logic [31:0] extracted, mask, wlane, merged;
  assign req_ready = state == IDLE && !Rst;
  assign accept = req_valid && req_ready;
  assign size_m1 = req_funct3[1] ? 2'd3 : {1'b0, req_funct3[0]};
  assign last = {1'b0, req_addr} + {{(ADDR_W-1){1'b0}}, size_m1};
  assign bad = (req_store ? req_funct3 >= 3'd3 : (req_funct3[1:0] == 2'd3 || req_funct3 == 3'b110))
            || (req_funct3[1:0] == 2'd1 && req_addr[0])
            || (req_funct3[1:0] == 2'd2 && req_addr[1:0] != 2'd0)
            || last >= (ADDR_W+1)'(MEM_BYTES);
  // Next state: SW skips the read, sub-word stores read then write, everything ends in a one-cycle response
  always_comb begin
    state_n = state == IDLE ? (accept ? (bad ? ERR : (req_store && req_funct3[1:0] == 2'd2) ? WR : RD) : IDLE)
            : state == RD   ? (store_q ? WR : RESP)
            : state == WR   ? RESP
            : IDLE;
  end
  // State, request latch on accept, and read buffer capture during RD
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state   <= IDLE;
      addr_q  <= '0;
      f3_q    <= '0;
      store_q <= 1'b0;
      wdata_q <= '0;
      rbuf    <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        addr_q  <= req_addr;
        f3_q    <= req_funct3;
        store_q <= req_store;
        wdata_q <= req_wdata;
      end
      if (state == RD) rbuf <= mem_rdata;
    end
  end
  assign lane_b = addr_q[1] ? (addr_q[0] ? rbuf[31:24] : rbuf[23:16]) : (addr_q[0] ? rbuf[15:8] : rbuf[7:0]);
  assign lane_h = addr_q[1] ? rbuf[31:16] : rbuf[15:0];
  assign extracted = f3_q[1] ? rbuf
                   : f3_q[0] ? {{16{lane_h[15] & ~f3_q[2]}}, lane_h}
                   : {{24{lane_b[7] & ~f3_q[2]}}, lane_b};
  assign mask = f3_q[1] ? 32'hFFFF_FFFF
              : f3_q[0] ? (addr_q[1] ? 32'hFFFF_0000 : 32'h0000_FFFF)
              : 32'h0000_00FF << {addr_q[1:0], 3'b000};
  assign wlane = f3_q[1] ? wdata_q : f3_q[0] ? {2{wdata_q[15:0]}} : {4{wdata_q[7:0]}};
  assign merged = (rbuf & ~mask) | (wlane & mask);
  assign mem_read  = state == RD;
  assign mem_write = state == WR;
  assign mem_addr  = (mem_read || mem_write) ? {addr_q[31:2], 2'b00} : 32'h0;
  assign mem_wdata = mem_write ? merged : 32'h0;
  assign rsp_valid = state == RESP || state == ERR;
  assign rsp_err   = state == ERR;
  assign rsp_rdata = (state == RESP && !store_q) ? extracted : 32'h0;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: randomized requests checked cycle by cycle against a byte-array reference model
module tb_load_store_unit;
  logic Clk = 0, Rst = 1;
  logic req_valid = 0, req_store = 0;
  logic [2:0] req_funct3 = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic req_ready, rsp_valid, rsp_err, mem_read, mem_write;
  logic [31:0] rsp_rdata, mem_addr, mem_wdata, mem_rdata;

  always #5 Clk = ~Clk;

  load_store_unit dut (
    .Clk(Clk), .Rst(Rst), .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_err(rsp_err), .rsp_rdata(rsp_rdata), .mem_addr(mem_addr), .mem_read(mem_read),
    .mem_write(mem_write), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  logic [31:0] mem [16];
  logic bd_we = 0;
  logic [3:0] bd_idx = 0;
  logic [31:0] bd_dat = 0;
  assign mem_rdata = mem_addr < 32'd64 ? mem[mem_addr[5:2]] : 32'h0;
  always @(posedge Clk) begin
    if (mem_write && mem_addr < 32'd64) mem[mem_addr[5:2]] = mem_wdata;
    else if (bd_we) mem[bd_idx] = bd_dat;
  end

  typedef struct {
    int acc;
    int lat;
    bit err;
    logic [31:0] rdata;
    bit rd;
    bit wr;
    logic [31:0] waddr;
    logic [31:0] wword;
  } exp_t;

  logic [7:0] refm [64];
  exp_t q[$];
  int cyc = 0, nchk = 0, npass = 0, rsp_count = 0, accepts = 0, issued = 0, last_lat = 0;
  logic [31:0] last_rdata = 0, last_wdata = 0;
  logic last_err = 0;
  bit chk_en = 0;

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", n, act, exp, $time);
  endtask

  function automatic exp_t model(bit st, logic [2:0] f3, logic [31:0] a, logic [31:0] wd);
    exp_t e;
    int sz, ai, base;
    logic [31:0] v;
    sz = f3[1:0] == 2'd0 ? 1 : f3[1:0] == 2'd1 ? 2 : 4;
    e.err = st ? (f3 >= 3) : (f3 == 3 || f3 == 6 || f3 == 7);
    if (sz == 2 && a % 2 != 0) e.err = 1;
    if (sz == 4 && a % 4 != 0) e.err = 1;
    if (longint'({32'h0, a}) + sz - 1 >= 64) e.err = 1;
    e.acc = 0; e.lat = 1; e.rdata = 0; e.rd = 0; e.wr = 0; e.wword = 0;
    e.waddr = a & ~32'd3;
    if (!e.err) begin
      ai = int'(a);
      base = ai & ~3;
      if (st) begin
        for (int i = 0; i < sz; i++) refm[ai+i] = wd[8*i +: 8];
        for (int i = 0; i < 4; i++) e.wword[8*i +: 8] = refm[base+i];
        e.wr = 1;
        e.rd = sz < 4;
        e.lat = sz < 4 ? 3 : 2;
      end else begin
        v = 0;
        for (int i = 0; i < sz; i++) v[8*i +: 8] = refm[ai+i];
        if (f3 == 0) v = {{24{v[7]}}, v[7:0]};
        if (f3 == 1) v = {{16{v[15]}}, v[15:0]};
        e.rdata = v;
        e.rd = 1;
        e.lat = 2;
      end
    end
    return e;
  endfunction

  always @(posedge Clk) begin
    cyc++;
    if (chk_en && !Rst && req_valid && req_ready) begin
      exp_t e;
      e = model(req_store, req_funct3, req_addr, req_wdata);
      e.acc = cyc;
      q.push_back(e);
      accepts++;
    end
  end

  always @(negedge Clk) if (chk_en) begin
    int ph;
    bit ev, er, ew;
    logic [31:0] ea;
    ev = 0; er = 0; ew = 0; ea = 0; ph = 0;
    chk("req_ready", req_ready, q.size() == 0);
    if (q.size() > 0) begin
      ph = cyc - q[0].acc + 1;
      ev = ph == q[0].lat;
      er = q[0].rd && ph == 1;
      ew = q[0].wr && ph == q[0].lat - 1;
      if (er || ew) ea = q[0].waddr;
    end
    chk("rsp_valid", rsp_valid, ev);
    chk("mem_read", mem_read, er);
    chk("mem_write", mem_write, ew);
    chk("mem_addr", mem_addr, ea);
    if (ew) begin
      chk("mem_wdata", mem_wdata, q[0].wword);
      last_wdata = mem_wdata;
    end
    if (ev) begin
      chk("rsp_err", rsp_err, q[0].err);
      chk("rsp_rdata", rsp_rdata, q[0].rdata);
      last_err = rsp_err;
      last_rdata = rsp_rdata;
      last_lat = ph;
      rsp_count++;
      void'(q.pop_front());
    end
  end

  task automatic issue(bit st, logic [2:0] f3, logic [31:0] a, logic [31:0] wd);
    @(negedge Clk);
    req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd; req_valid = 1;
    for (int i = 0; i < 40 && !req_ready; i++) @(negedge Clk);
    chk("ready_timeout", req_ready, 1);
    issued++;
    @(posedge Clk);
  endtask

  task automatic release_req();
    @(negedge Clk);
    req_valid = 0;
  endtask

  task automatic wait_rsp(int target);
    for (int i = 0; i < 40; i++) begin
      @(negedge Clk);
      #1;
      if (rsp_count >= target) break;
    end
    chk("rsp_timeout", rsp_count >= target, 1);
  endtask

  task automatic lit(string n, bit st, logic [2:0] f3, logic [31:0] a, logic [31:0] wd,
                     logic err, logic [31:0] rd, int lat);
    int n0;
    n0 = rsp_count;
    issue(st, f3, a, wd);
    release_req();
    wait_rsp(n0 + 1);
    chk({n, "_err"}, last_err, err);
    chk({n, "_rdata"}, last_rdata, rd);
    chk({n, "_lat"}, last_lat, lat);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    int n0, r, sz;
    bit st;
    logic [2:0] f3;
    logic [31:0] a, w;
    for (int i = 0; i < 16; i++) begin
      @(negedge Clk);
      w = i == 2 ? 32'h8899AABB : i == 3 ? 32'hCAFEF00D : $urandom;
      bd_we = 1; bd_idx = 4'(i); bd_dat = w;
      for (int b = 0; b < 4; b++) refm[4*i+b] = w[8*b +: 8];
    end
    @(negedge Clk);
    bd_we = 0;
    chk("reset_ready", req_ready, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_err", rsp_err, 0);
    chk("reset_rsp_rdata", rsp_rdata, 0);
    chk("reset_mem_read", mem_read, 0);
    chk("reset_mem_write", mem_write, 0);
    chk("reset_mem_addr", mem_addr, 0);
    chk("reset_mem_wdata", mem_wdata, 0);
    @(negedge Clk);
    Rst = 0;
    #1 chk("ready_after_reset", req_ready, 1);

    @(negedge Clk);
    req_store = 1; req_funct3 = 3'd0; req_addr = 32'h0D; req_wdata = 32'h55; req_valid = 1;
    @(posedge Clk);
    @(negedge Clk);
    req_valid = 0;
    for (int i = 0; i < 5 && !mem_write; i++) @(negedge Clk);
    chk("t1_write_seen", mem_write, 1);
    #1 Rst = 1;
    #1;
    chk("t1_write_drop", mem_write, 0);
    chk("t1_read_drop", mem_read, 0);
    chk("t1_no_rsp", rsp_valid, 0);
    chk("t1_ready_in_rst", req_ready, 0);
    @(negedge Clk);
    Rst = 0;
    #1;
    chk("t1_ready_after", req_ready, 1);
    chk("t1_mem_unchanged", mem[3], 32'hCAFEF00D);
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      #1 chk("t1_still_no_rsp", rsp_valid, 0);
    end
    chk_en = 1;

    lit("lw08", 0, 3'd2, 32'h08, 0, 0, 32'h8899AABB, 2);
    lit("lb0b", 0, 3'd0, 32'h0B, 0, 0, 32'hFFFFFF88, 2);
    lit("lbu0b", 0, 3'd4, 32'h0B, 0, 0, 32'h00000088, 2);
    lit("lh0a", 0, 3'd1, 32'h0A, 0, 0, 32'hFFFF8899, 2);
    lit("lhu08", 0, 3'd5, 32'h08, 0, 0, 32'h0000AABB, 2);
    lit("sb09", 1, 3'd0, 32'h09, 32'h12345677, 0, 0, 3);
    chk("sb09_wdata", last_wdata, 32'h889977BB);
    lit("sw08", 1, 3'd2, 32'h08, 32'h8899AABB, 0, 0, 2);
    lit("sh0a", 1, 3'd1, 32'h0A, 32'h00001234, 0, 0, 3);
    chk("sh0a_wdata", last_wdata, 32'h1234AABB);
    lit("lw06", 0, 3'd2, 32'h06, 0, 1, 0, 1);
    lit("sh03", 1, 3'd1, 32'h03, 32'hFFFF, 1, 0, 1);
    lit("lw40", 0, 3'd2, 32'h40, 0, 1, 0, 1);
    lit("ld011", 0, 3'd3, 32'h00, 0, 1, 0, 1);
    lit("sf3_4", 1, 3'd4, 32'h00, 0, 1, 0, 1);
    lit("lh3f", 0, 3'd1, 32'h3F, 0, 1, 0, 1);
    lit("lbu40", 0, 3'd4, 32'h40, 0, 1, 0, 1);
    lit("sb3f", 1, 3'd0, 32'h3F, 32'hA5, 0, 0, 3);

    n0 = rsp_count;
    issue(0, 3'd4, 32'h08, 0);
    issue(0, 3'd5, 32'h0A, 0);
    issue(0, 3'd2, 32'h08, 0);
    release_req();
    wait_rsp(n0 + 3);
    chk("queued_count", rsp_count - n0, 3);
    chk("queued_last", last_rdata, 32'h1234AABB);

    for (int k = 0; k < 400; k++) begin
      st = 1'($urandom % 2);
      if ($urandom % 4 == 0) f3 = 3'($urandom % 8);
      else begin
        r = st ? $urandom % 3 : $urandom % 5;
        f3 = r < 3 ? 3'(r) : 3'(r + 1);
      end
      r = $urandom % 8;
      a = r < 6 ? $urandom_range(0, 66) : r == 6 ? $urandom_range(60, 70) : $urandom;
      sz = f3[1:0] == 2'd0 ? 1 : f3[1:0] == 2'd1 ? 2 : 4;
      if ($urandom % 2 == 0) a = a & ~(32'(sz) - 1);
      issue(st, f3, a, $urandom);
      if ($urandom % 2 == 0) begin
        release_req();
        repeat ($urandom % 3) @(negedge Clk);
      end
    end
    release_req();
    for (int i = 0; i < 40 && q.size() != 0; i++) @(negedge Clk);
    #1;
    chk("drain_empty", q.size(), 0);
    chk("accepts_match", accepts, issued);
    for (int i = 0; i < 16; i++) begin
      for (int b = 0; b < 4; b++) w[8*b +: 8] = refm[4*i+b];
      chk("mem_final", mem[i], w);
    end
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
